// File: rtl/ms_latch_pkg.sv
// Shared types and helpers for the master-slave latch sequencer.
package ms_latch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        M_OPEN = 3'd1,
        GAP    = 3'd2,
        S_OPEN = 3'd3,
        ACK    = 3'd4
    } state_t;

    localparam int DEAD_DEF = 2;

    // An open count of zero would give a zero-length enable pulse; treat it as one.
    function automatic int unsigned eff_open(input int unsigned oc);
        return (oc == 0) ? 32'd1 : oc;
    endfunction

endpackage

// File: rtl/ms_latch_seq_phase_timer.sv
// Loadable down-counter shared by all enable/dead-time phases; zero flags phase end.
// Latency: load takes effect next cycle; no backpressure, counts freely to zero and holds.
module phase_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          clear,
    output logic          zero
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ms_latch_seq.sv
// Sequences master enable, dead time and slave enable for a latch bank; ack at 2N+DEAD after accept.
// Backpressure: req is only sampled in IDLE, so a held req simply waits; abort cancels in-flight phases.
module ms_latch_seq
    import ms_latch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEAD  = DEAD_DEF,
    parameter int OW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] din,
    input  logic [OW-1:0]    open_cycles,
    input  logic             abort,
    output logic             busy,
    output logic             ack,
    output logic             aborted,
    output logic             en_m,
    output logic             en_s,
    output logic [WIDTH-1:0] d_lat,
    output logic [7:0]       xfer_cnt
);

    localparam int DW = $clog2(DEAD + 1);
    localparam int CW = (OW > DW) ? OW : DW;

    state_t           state_q, state_d;
    logic [CW-1:0]    nm1_q, nm1_d;
    logic [CW-1:0]    nm1_in;
    logic             tmr_load, tmr_clear, tmr_zero;
    logic [CW-1:0]    tmr_val;
    logic             busy_d, ack_d, aborted_d, en_m_d, en_s_d;
    logic [WIDTH-1:0] d_lat_d;
    logic [7:0]       xfer_cnt_d;

    assign nm1_in = CW'(eff_open(32'(open_cycles)) - 32'd1);

    phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .clear    (tmr_clear),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        nm1_d      = nm1_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_clear  = 1'b0;
        ack_d      = 1'b0;
        aborted_d  = 1'b0;
        en_m_d     = 1'b0;
        en_s_d     = 1'b0;
        d_lat_d    = d_lat;
        xfer_cnt_d = xfer_cnt;

        case (state_q)
            IDLE: begin
                if (req && !abort) begin
                    state_d  = M_OPEN;
                    nm1_d    = nm1_in;
                    tmr_load = 1'b1;
                    tmr_val  = nm1_in;
                    d_lat_d  = din;
                    en_m_d   = 1'b1;
                end
            end
            M_OPEN: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    tmr_clear = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(DEAD - 1);
                end else begin
                    en_m_d = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    tmr_clear = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = S_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = nm1_q;
                    en_s_d   = 1'b1;
                end
            end
            S_OPEN: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    tmr_clear = 1'b1;
                end else if (tmr_zero) begin
                    state_d    = ACK;
                    ack_d      = 1'b1;
                    xfer_cnt_d = xfer_cnt + 8'd1;
                    tmr_clear  = 1'b1;
                end else begin
                    en_s_d = 1'b1;
                end
            end
            ACK: begin
                // abort is deliberately ignored here: the transfer already completed
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                tmr_clear = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            nm1_q    <= '0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            aborted  <= 1'b0;
            en_m     <= 1'b0;
            en_s     <= 1'b0;
            d_lat    <= '0;
            xfer_cnt <= '0;
        end else begin
            state_q  <= state_d;
            nm1_q    <= nm1_d;
            busy     <= busy_d;
            ack      <= ack_d;
            aborted  <= aborted_d;
            en_m     <= en_m_d;
            en_s     <= en_s_d;
            d_lat    <= d_lat_d;
            xfer_cnt <= xfer_cnt_d;
        end
    end

endmodule

// File: tb/tb_ms_latch_seq.sv
// Directed bench for ms_latch_seq: DEAD=2 main instance plus a DEAD=1 instance for the minimum-timing case.
module tb_ms_latch_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [7:0] din = 8'h00;
    logic [3:0] open_cycles = 4'd0;
    logic       abort = 1'b0;

    logic       busy, ack, aborted, en_m, en_s;
    logic [7:0] d_lat, xfer_cnt;
    logic       busy1, ack1, aborted1, en_m1, en_s1;
    logic [7:0] d_lat1, xfer_cnt1;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    ms_latch_seq #(.WIDTH(8), .DEAD(2), .OW(4)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .open_cycles(open_cycles), .abort(abort),
        .busy(busy), .ack(ack), .aborted(aborted), .en_m(en_m), .en_s(en_s),
        .d_lat(d_lat), .xfer_cnt(xfer_cnt)
    );

    ms_latch_seq #(.WIDTH(8), .DEAD(1), .OW(4)) dut1 (
        .clk(clk), .rst(rst), .req(req), .din(din), .open_cycles(open_cycles), .abort(abort),
        .busy(busy1), .ack(ack1), .aborted(aborted1), .en_m(en_m1), .en_s(en_s1),
        .d_lat(d_lat1), .xfer_cnt(xfer_cnt1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [4:0] got;
        #3 rst = 1'b0;
        #4;
        got = {busy, ack, aborted, en_m, en_s};
        total++;
        if (got !== 5'b0) begin
            bad++; $display("FAIL reset_ctl got=%b exp=00000", got);
        end
        total++;
        if ({d_lat, xfer_cnt} !== 16'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0000", {d_lat, xfer_cnt});
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle busy got=%b exp=0", busy);
        end
        exp_cnt = 0;
    endtask

    task automatic test_basic;
        logic [3:0] exp_v;
        req = 1'b1; din = 8'hA5; open_cycles = 4'd3;
        for (int k = 0; k <= 9; k++) begin
            tick();
            if (k == 0) begin
                req = 1'b0; din = 8'h00; open_cycles = 4'd7;
            end
            exp_v = {k < 3, (k >= 5 && k < 8), k == 8, k <= 8};
            total++;
            if ({en_m, en_s, ack, busy} !== exp_v) begin
                bad++; $display("FAIL basic_E%0d {en_m,en_s,ack,busy} got=%b exp=%b", k, {en_m, en_s, ack, busy}, exp_v);
            end
            if (k == 0 || k == 9) begin
                total++;
                if (d_lat !== 8'hA5) begin
                    bad++; $display("FAIL basic_dlat_E%0d got=%h exp=a5", k, d_lat);
                end
            end
        end
        exp_cnt++;
        total++;
        if (xfer_cnt !== 8'(exp_cnt)) begin
            bad++; $display("FAIL basic_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt);
        end
    endtask

    task automatic test_zero_open;
        logic [3:0] exp_v;
        rst = 1'b0; #2; rst = 1'b1;
        exp_cnt = 0;
        req = 1'b1; din = 8'h3C; open_cycles = 4'd0;
        for (int k = 0; k <= 4; k++) begin
            tick();
            if (k == 0) req = 1'b0;
            exp_v = {k == 0, k == 2, k == 3, k <= 3};
            total++;
            if ({en_m1, en_s1, ack1, busy1} !== exp_v) begin
                bad++; $display("FAIL zero_E%0d {en_m,en_s,ack,busy} got=%b exp=%b", k, {en_m1, en_s1, ack1, busy1}, exp_v);
            end
        end
        total++;
        if ({d_lat1, xfer_cnt1} !== {8'h3C, 8'd1}) begin
            bad++; $display("FAIL zero_data got=%h exp=3c01", {d_lat1, xfer_cnt1});
        end
        tick(); tick();
        exp_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_v;
        logic [7:0] exp_d;
        int p;
        req = 1'b1; open_cycles = 4'd2;
        for (int k = 0; k <= 23; k++) begin
            din = 8'(8'h10 + k);
            tick();
            p = k % 8;
            exp_v = {p < 2, (p >= 4 && p < 6), p == 6, p <= 6};
            exp_d = 8'(8'h10 + 8 * (k / 8));
            total++;
            if ({en_m, en_s, ack, busy} !== exp_v || d_lat !== exp_d) begin
                bad++; $display("FAIL b2b_E%0d ctl got=%b exp=%b d_lat got=%h exp=%h", k, {en_m, en_s, ack, busy}, exp_v, d_lat, exp_d);
            end
            if (en_m && en_s) begin
                bad++; $display("FAIL b2b_overlap_E%0d en_m=1 en_s=1 exp not both", k);
            end
        end
        req = 1'b0;
        exp_cnt += 3;
        total++;
        if (xfer_cnt !== 8'(exp_cnt)) begin
            bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt);
        end
    endtask

    task automatic test_abort;
        req = 1'b1; open_cycles = 4'd3; din = 8'h5A;
        tick();
        din = 8'hC3;
        tick(); tick(); tick();
        total++;
        if ({en_m, en_s, busy} !== 3'b001) begin
            bad++; $display("FAIL abort_gap {en_m,en_s,busy} got=%b exp=001", {en_m, en_s, busy});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({en_m, en_s, ack, aborted, busy} !== 5'b00010) begin
            bad++; $display("FAIL abort_edge {en_m,en_s,ack,aborted,busy} got=%b exp=00010", {en_m, en_s, ack, aborted, busy});
        end
        total++;
        if (xfer_cnt !== 8'(exp_cnt) || d_lat !== 8'h5A) begin
            bad++; $display("FAIL abort_hold cnt=%0d exp=%0d d_lat=%h exp=5a", xfer_cnt, exp_cnt, d_lat);
        end
        tick();
        req = 1'b0;
        total++;
        if ({en_m, aborted, busy} !== 3'b101 || d_lat !== 8'hC3) begin
            bad++; $display("FAIL abort_reaccept {en_m,aborted,busy} got=%b exp=101 d_lat=%h exp=c3", {en_m, aborted, busy}, d_lat);
        end
        repeat (9) tick();
        exp_cnt++;
        total++;
        if (busy !== 1'b0 || xfer_cnt !== 8'(exp_cnt)) begin
            bad++; $display("FAIL abort_done busy=%b exp=0 cnt=%0d exp=%0d", busy, xfer_cnt, exp_cnt);
        end
    endtask

    task automatic test_abort_idle;
        req = 1'b1; abort = 1'b1; open_cycles = 4'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({busy, en_m, aborted} !== 3'b000) begin
                bad++; $display("FAIL abort_idle_E%0d {busy,en_m,aborted} got=%b exp=000", k, {busy, en_m, aborted});
            end
        end
        req = 1'b0; abort = 1'b0;
    endtask

    task automatic test_wrap;
        rst = 1'b0; #2; rst = 1'b1;
        exp_cnt = 0;
        req = 1'b1; open_cycles = 4'd1;
        for (int k = 0; k <= 1534; k++) begin
            tick();
            if (k == 1528) begin
                total++;
                if (xfer_cnt !== 8'd255) begin
                    bad++; $display("FAIL wrap_255 got=%0d exp=255", xfer_cnt);
                end
            end
        end
        req = 1'b0;
        total++;
        if ({ack, xfer_cnt} !== {1'b1, 8'd0}) begin
            bad++; $display("FAIL wrap_0 {ack,cnt} got=%b,%0d exp=1,0", ack, xfer_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        req = 1'b1; open_cycles = 4'd3; din = 8'h77;
        for (int k = 0; k <= 5; k++) begin
            tick();
            if (k == 0) req = 1'b0;
        end
        total++;
        if (en_s !== 1'b1) begin
            bad++; $display("FAIL mid_sopen en_s got=%b exp=1", en_s);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({busy, ack, aborted, en_m, en_s, d_lat, xfer_cnt} !== 21'h0) begin
            bad++; $display("FAIL mid_reset outs got=%h exp=0", {busy, ack, aborted, en_m, en_s, d_lat, xfer_cnt});
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        total++;
        if ({busy, en_m, en_s} !== 3'b000) begin
            bad++; $display("FAIL mid_release {busy,en_m,en_s} got=%b exp=000", {busy, en_m, en_s});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_open();
        test_back_to_back();
        test_abort();
        test_abort_idle();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
